// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : RV32I pipeline hazard/sequencing controller: scoreboard stalls,
//            redirect squash and ECALL/EBREAK drain-to-halt.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_sel,
    input  logic [4:0]       id_rs2_sel,
    input  logic [4:0]       id_rd_sel,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_wb_en,
    input  logic             id_env,
    input  logic             ex_redirect,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd_sel,
    input  logic             mem_busy,
    output logic             halt_if,
    output logic             halt_id,
    output logic             flush_id,
    output logic             pc_redirect_en,
    output logic [WIDTH-1:0] pc_redirect,
    output logic [31:0]      pending,
    output logic             halted,
    output logic [31:0]      stall_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] c_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic [31:0] r_pending, w_pending_next;
    logic [31:0] r_stall_count;
    logic [31:0] w_clr, w_set, w_busy;
    logic        w_run, w_hz, w_stall, w_issue, w_redirect;

    // Writeback clears in the same cycle so a waiting reader sees it at once.
    assign w_clr  = wb_valid ? (32'd1 << wb_rd_sel) : 32'd0;
    assign w_busy = r_pending & ~w_clr;

    assign w_hz = id_valid & (
                  (id_uses_rs1 & (id_rs1_sel != 5'd0) & w_busy[id_rs1_sel]) |
                  (id_uses_rs2 & (id_rs2_sel != 5'd0) & w_busy[id_rs2_sel]) |
                  (id_wb_en    & (id_rd_sel  != 5'd0) & w_busy[id_rd_sel]));

    assign w_run      = (r_state == S_RUN);
    assign w_stall    = w_run & (w_hz | mem_busy);
    assign w_issue    = w_run & id_valid & ~w_stall & ~ex_redirect & ~id_env;
    assign w_redirect = ex_redirect & (r_state != S_HALTED);

    assign w_set = (w_issue & id_wb_en & (id_rd_sel != 5'd0)) ? (32'd1 << id_rd_sel) : 32'd0;

    always_comb begin
        w_pending_next    = (r_pending & ~w_clr) | w_set;
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_redirect) begin
            // Also cancels a drain: the env instruction was on the wrong path.
            w_state_next = S_FLUSH;
            w_cnt_next   = c_CNT_INIT;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (id_valid & id_env)
                        w_state_next = S_DRAIN;
                end
                S_FLUSH: begin
                    if (r_cnt == 3'd0)
                        w_state_next = S_RUN;
                    else
                        w_cnt_next = r_cnt - 3'd1;
                end
                S_DRAIN: begin
                    if (w_pending_next == 32'd0)
                        w_state_next = S_HALTED;
                end
                default: w_state_next = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_cnt         <= 3'd0;
            r_pending     <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign halt_if        = w_stall | (r_state == S_DRAIN) | (r_state == S_HALTED);
    assign halt_id        = halt_if;
    // A stall also bubbles EX while decode holds its instruction.
    assign flush_id       = ex_redirect | w_stall | (r_state != S_RUN);
    assign pc_redirect_en = w_redirect;
    assign pc_redirect    = w_redirect ? ex_target : '0;
    assign pending        = r_pending;
    assign halted         = (r_state == S_HALTED);
    assign stall_count    = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed vector table plus hand sequences for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_wb_en, id_env;
    logic [4:0]  id_rs1_sel, id_rs2_sel, id_rd_sel, wb_rd_sel;
    logic        ex_redirect, wb_valid, mem_busy;
    logic [31:0] ex_target;
    logic        halt_if, halt_id, flush_id, pc_redirect_en, halted;
    logic [31:0] pc_redirect, pending, stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WIDTH(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel),
        .id_rd_sel(id_rd_sel), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_wb_en(id_wb_en), .id_env(id_env), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .wb_valid(wb_valid), .wb_rd_sel(wb_rd_sel),
        .mem_busy(mem_busy), .halt_if(halt_if), .halt_id(halt_id),
        .flush_id(flush_id), .pc_redirect_en(pc_redirect_en),
        .pc_redirect(pc_redirect), .pending(pending), .halted(halted),
        .stall_count(stall_count)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wb, env, redir;
        logic [31:0] tgt;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        mb;
        logic        e_halt, e_flush, e_pre;
        logic [31:0] e_prpc, e_pend;
        logic        e_halted;
        logic [31:0] e_scnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(
        input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic u1, input logic u2, input logic wb, input logic env, input logic redir,
        input logic [31:0] tgt, input logic wbv, input logic [4:0] wbrd, input logic mb,
        input logic e_halt, input logic e_flush, input logic e_pre, input logic [31:0] e_prpc,
        input logic [31:0] e_pend, input logic e_halted, input logic [31:0] e_scnt);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.wb = wb;
        r.env = env; r.redir = redir; r.tgt = tgt; r.wbv = wbv; r.wbrd = wbrd; r.mb = mb;
        r.e_halt = e_halt; r.e_flush = e_flush; r.e_pre = e_pre; r.e_prpc = e_prpc;
        r.e_pend = e_pend; r.e_halted = e_halted; r.e_scnt = e_scnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_sel = 0; id_rs2_sel = 0; id_rd_sel = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_wb_en = 0; id_env = 0;
        ex_redirect = 0; ex_target = 0; wb_valid = 0; wb_rd_sel = 0; mem_busy = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        id_valid = 1; id_rd_sel = rd; id_wb_en = 1;
        @(negedge clk);
        next_cycle();
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        @(negedge clk);
        chk("reset.halt_if", halt_if, 0);
        chk("reset.flush_id", flush_id, 0);
        chk("reset.pc_redirect_en", pc_redirect_en, 0);
        chk("reset.pc_redirect", pc_redirect, 0);
        chk("reset.pending", pending, 0);
        chk("reset.halted", halted, 0);
        chk("reset.stall_count", stall_count, 0);
        next_cycle();

        //         v rs1 rs2 rd u1 u2 wb env rdr tgt     wbv wbrd mb | halt flush pre prpc    pend   hltd scnt
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,0)); // idle
        vq.push_back(mkv(1,0,0,5, 0,0,1,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,0)); // issue x5
        vq.push_back(mkv(1,5,0,0, 1,0,0,0,0, 0,      0,0,0,  1,1,0,0,      'h20,  0,0)); // RAW stall
        vq.push_back(mkv(1,5,0,0, 1,0,0,0,0, 0,      0,0,0,  1,1,0,0,      'h20,  0,1));
        vq.push_back(mkv(1,5,0,0, 1,0,0,0,0, 0,      1,5,0,  0,0,0,0,      'h20,  0,2)); // wb releases
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2));
        vq.push_back(mkv(1,0,0,7, 0,0,1,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2)); // issue x7
        vq.push_back(mkv(1,0,0,7, 0,0,1,0,0, 0,      1,7,0,  0,0,0,0,      'h80,  0,2)); // set+clr x7
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      'h80,  0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      1,7,0,  0,0,0,0,      'h80,  0,2));
        vq.push_back(mkv(1,0,0,0, 0,0,1,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2)); // rd=x0
        vq.push_back(mkv(1,0,0,0, 1,1,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2)); // read x0
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      1,0,0,  0,0,0,0,      0,     0,2)); // wb x0
        vq.push_back(mkv(1,0,0,9, 0,0,1,0,1, 'h100,  0,0,0,  0,1,1,'h100,  0,     0,2)); // redirect
        vq.push_back(mkv(1,0,0,9, 0,0,1,0,0, 0,      0,0,1,  0,1,0,0,      0,     0,2)); // FLUSH + mem_busy
        vq.push_back(mkv(1,0,0,9, 0,0,1,0,0, 0,      0,0,1,  0,1,0,0,      0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2)); // RUN again
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,1, 'h200,  0,0,0,  0,1,1,'h200,  0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,1,0,0,      0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,1, 'h300,  0,0,0,  0,1,1,'h300,  0,     0,2)); // restart
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,1,0,0,      0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,1,0,0,      0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,2));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,1,  1,1,0,0,      0,     0,2)); // mem_busy x4
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,1,  1,1,0,0,      0,     0,3));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,1,  1,1,0,0,      0,     0,4));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,1,  1,1,0,0,      0,     0,5));
        vq.push_back(mkv(0,0,0,0, 0,0,0,0,0, 0,      0,0,0,  0,0,0,0,      0,     0,6));

        for (int i = 0; i < vq.size(); i++) begin
            id_valid = vq[i].v; id_rs1_sel = vq[i].rs1; id_rs2_sel = vq[i].rs2;
            id_rd_sel = vq[i].rd; id_uses_rs1 = vq[i].u1; id_uses_rs2 = vq[i].u2;
            id_wb_en = vq[i].wb; id_env = vq[i].env; ex_redirect = vq[i].redir;
            ex_target = vq[i].tgt; wb_valid = vq[i].wbv; wb_rd_sel = vq[i].wbrd;
            mem_busy = vq[i].mb;
            @(negedge clk);
            chk($sformatf("row%0d.halt_if", i), halt_if, vq[i].e_halt);
            chk($sformatf("row%0d.halt_id", i), halt_id, vq[i].e_halt);
            chk($sformatf("row%0d.flush_id", i), flush_id, vq[i].e_flush);
            chk($sformatf("row%0d.pc_redirect_en", i), pc_redirect_en, vq[i].e_pre);
            chk($sformatf("row%0d.pc_redirect", i), pc_redirect, vq[i].e_prpc);
            chk($sformatf("row%0d.pending", i), pending, vq[i].e_pend);
            chk($sformatf("row%0d.halted", i), halted, vq[i].e_halted);
            chk($sformatf("row%0d.stall_count", i), stall_count, vq[i].e_scnt);
            next_cycle();
        end

        // ECALL drain with x3 and x9 in flight
        issue_rd(5'd3);
        issue_rd(5'd9);
        id_valid = 1; id_env = 1;
        @(negedge clk);
        chk("ecall.decode_halt", halt_if, 0);
        chk("ecall.decode_pending", pending, 32'h208);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin wb_valid = 1; wb_rd_sel = 5'd3; end
            if (k == 4) begin wb_valid = 1; wb_rd_sel = 5'd9; end
            @(negedge clk);
            chk($sformatf("drain%0d.halt_if", k), halt_if, 1);
            chk($sformatf("drain%0d.flush_id", k), flush_id, 1);
            chk($sformatf("drain%0d.halted", k), halted, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("halt.halted", halted, 1);
        chk("halt.halt_id", halt_id, 1);
        chk("halt.pending", pending, 0);
        next_cycle();
        ex_redirect = 1; ex_target = 32'h500;
        @(negedge clk);
        chk("halt.redirect_ignored", pc_redirect_en, 0);
        next_cycle();
        @(negedge clk);
        chk("halt.still_halted", halted, 1);
        chk("halt.still_flush", flush_id, 1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("halt_reset.halted", halted, 0);
        chk("halt_reset.halt_if", halt_if, 0);
        chk("halt_reset.flush_id", flush_id, 0);
        chk("halt_reset.stall_count", stall_count, 0);
        next_cycle();

        // redirect in first DRAIN cycle cancels the halt
        issue_rd(5'd4);
        id_valid = 1; id_env = 1;
        @(negedge clk);
        next_cycle();
        ex_redirect = 1; ex_target = 32'h40;
        @(negedge clk);
        chk("cancel.pc_redirect_en", pc_redirect_en, 1);
        chk("cancel.pc_redirect", pc_redirect, 32'h40);
        chk("cancel.halt_if", halt_if, 1);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("cancel_flush%0d.flush_id", k), flush_id, 1);
            chk($sformatf("cancel_flush%0d.halt_if", k), halt_if, 0);
            chk($sformatf("cancel_flush%0d.halted", k), halted, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("cancel_run.flush_id", flush_id, 0);
        chk("cancel_run.halted", halted, 0);
        chk("cancel_run.pending", pending, 32'h10);
        next_cycle();

        // reset mid-FLUSH with x4 still pending
        ex_redirect = 1; ex_target = 32'h80;
        @(negedge clk);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("flush_reset.in_flush", flush_id, 1);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("flush_reset.flush_id", flush_id, 0);
        chk("flush_reset.pending", pending, 0);
        chk("flush_reset.halted", halted, 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
